// File: rtl/mem_read_unit.sv
// Read-side initiator: issues a one-cycle strobe to memory, waits for the ack
// (bounded by TIMEOUT), and holds the word or a timeout error until consumed.
module mem_read_unit #(
   parameter int DATA_WIDTH = 18,
   parameter int ADDR_WIDTH = 10,
   parameter int TIMEOUT    = 15
) (
   input  logic                  CLK,
   input  logic                  clear,
   input  logic                  req_valid,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  req_ready,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_err,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t     state_r;
   logic [7:0] count_r;

   // Transaction FSM; every output is a register updated alongside the state.
   always_ff @(posedge CLK) begin
      if (clear) begin
         state_r   <= ST_IDLE;
         count_r   <= 8'd0;
         req_ready <= 1'b1;
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  mem_addr  <= req_addr;
                  count_r   <= 8'd0;
                  req_ready <= 1'b0;
                  mem_rd_en <= 1'b1;
                  busy      <= 1'b1;
                  state_r   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               mem_rd_en <= 1'b0;
               if (mem_ack) begin
                  rsp_data  <= mem_rdata;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state_r   <= ST_RESP;
               end else begin
                  count_r <= 8'd1;
                  state_r <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // An ack in the final wait cycle still beats the timeout.
               if (mem_ack) begin
                  rsp_data  <= mem_rdata;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state_r   <= ST_RESP;
               end else if (count_r == TIMEOUT_C) begin
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state_r   <= ST_RESP;
               end else begin
                  count_r <= count_r + 8'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  state_r   <= ST_IDLE;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               req_ready <= 1'b1;
               mem_rd_en <= 1'b0;
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_read_unit.sv
// Directed bench for mem_read_unit: zero-wait, wait states, timeout boundary,
// backpressure, mid-transaction reset and back-to-back reads.
module tb_mem_read_unit;

   logic        CLK = 1'b0;
   logic        clear;
   logic        req_valid;
   logic [9:0]  req_addr;
   logic        req_ready;
   logic        mem_rd_en;
   logic [9:0]  mem_addr;
   logic        mem_ack;
   logic [17:0] mem_rdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [17:0] rsp_data;
   logic        rsp_err;
   logic        busy;

   int tests = 0;
   int fails = 0;
   int cycle_cnt = 0;
   int last_rsp = 0;

   mem_read_unit #(.DATA_WIDTH(18), .ADDR_WIDTH(10), .TIMEOUT(15)) dut (
      .CLK(CLK), .clear(clear), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(req_ready), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cycle_cnt <= cycle_cnt + 1;

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_rd_en"},     32'(mem_rd_en), 32'd0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_busy"},      32'(busy),      32'd0);
   endtask

   logic [9:0]  b2b_addr [4];
   logic [17:0] b2b_data [4];

   initial begin
      b2b_addr[0] = 10'h000; b2b_data[0] = 18'h00001;
      b2b_addr[1] = 10'h3FF; b2b_data[1] = 18'h3FFFE;
      b2b_addr[2] = 10'h200; b2b_data[2] = 18'h20000;
      b2b_addr[3] = 10'h0AA; b2b_data[3] = 18'h0AA55;

      clear = 1'b1; req_valid = 1'b0; req_addr = 10'h000;
      mem_ack = 1'b0; mem_rdata = 18'h00000; rsp_ready = 1'b0;
      cyc(); cyc();
      check_idle("reset");
      check("reset_addr", 32'(mem_addr), 32'h0);
      check("reset_data", 32'(rsp_data), 32'h0);
      check("reset_err",  32'(rsp_err),  32'h0);
      clear = 1'b0;

      // Zero-wait read
      req_valid = 1'b1; req_addr = 10'h155; rsp_ready = 1'b1;
      cyc();
      check("zw_rd_en", 32'(mem_rd_en), 32'd1);
      check("zw_addr",  32'(mem_addr),  32'h155);
      check("zw_ready", 32'(req_ready), 32'd0);
      check("zw_busy",  32'(busy),      32'd1);
      req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 18'h2ABCD;
      cyc();
      check("zw_valid", 32'(rsp_valid), 32'd1);
      check("zw_data",  32'(rsp_data),  32'h2ABCD);
      check("zw_err",   32'(rsp_err),   32'd0);
      check("zw_rd_en_once", 32'(mem_rd_en), 32'd0);
      mem_ack = 1'b0;
      cyc();
      check_idle("zw_done");
      check("zw_data_hold", 32'(rsp_data), 32'h2ABCD);

      // Wait states: ack in the 5th cycle after the strobe, then a stray second ack
      req_valid = 1'b1; req_addr = 10'h0F0;
      cyc();
      req_valid = 1'b0;
      cyc();
      for (int i = 1; i <= 4; i++) begin
         check("ws_busy",  32'(busy),      32'd1);
         check("ws_valid", 32'(rsp_valid), 32'd0);
         check("ws_rd_en", 32'(mem_rd_en), 32'd0);
         cyc();
      end
      check("ws_busy5", 32'(busy), 32'd1);
      mem_ack = 1'b1; mem_rdata = 18'h3FFFF;
      cyc();
      check("ws_valid", 32'(rsp_valid), 32'd1);
      check("ws_data",  32'(rsp_data),  32'h3FFFF);
      check("ws_err",   32'(rsp_err),   32'd0);
      mem_rdata = 18'h12345;
      cyc();
      mem_ack = 1'b0;
      check("ws_second_ack", 32'(rsp_data), 32'h3FFFF);
      check_idle("ws_done");

      // Timeout with no ack
      req_valid = 1'b1; req_addr = 10'h010;
      cyc();
      req_valid = 1'b0;
      cyc();
      repeat (14) cyc();
      check("to_not_yet", 32'(rsp_valid), 32'd0);
      cyc();
      check("to_valid", 32'(rsp_valid), 32'd1);
      check("to_err",   32'(rsp_err),   32'd1);
      check("to_data",  32'(rsp_data),  32'h0);
      cyc();
      check_idle("to_done");

      // Ack in exactly the 15th wait cycle
      req_valid = 1'b1; req_addr = 10'h011;
      cyc();
      req_valid = 1'b0;
      cyc();
      repeat (14) cyc();
      check("tb15_not_yet", 32'(rsp_valid), 32'd0);
      mem_ack = 1'b1; mem_rdata = 18'h1A5A5;
      cyc();
      mem_ack = 1'b0;
      check("tb15_valid", 32'(rsp_valid), 32'd1);
      check("tb15_err",   32'(rsp_err),   32'd0);
      check("tb15_data",  32'(rsp_data),  32'h1A5A5);
      cyc();
      check_idle("tb15_done");

      // Backpressure in RESP
      rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 10'h2AA;
      cyc();
      req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 18'h15555;
      cyc();
      for (int i = 0; i < 10; i++) begin
         req_valid = i[0]; mem_ack = ~i[0]; mem_rdata = 18'(i * 32'h1111);
         req_addr = 10'(i);
         cyc();
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_data",  32'(rsp_data),  32'h15555);
         check("bp_err",   32'(rsp_err),   32'd0);
         check("bp_ready", 32'(req_ready), 32'd0);
         check("bp_rd_en", 32'(mem_rd_en), 32'd0);
         check("bp_addr",  32'(mem_addr),  32'h2AA);
      end
      req_valid = 1'b0; mem_ack = 1'b0; rsp_ready = 1'b1;
      cyc();
      check_idle("bp_release");

      // Reset in WAIT, then a late ack
      req_valid = 1'b1; req_addr = 10'h0CC;
      cyc();
      req_valid = 1'b0;
      cyc(); cyc(); cyc();
      clear = 1'b1;
      cyc();
      clear = 1'b0; mem_ack = 1'b1; mem_rdata = 18'h3C3C3;
      cyc();
      mem_ack = 1'b0;
      check_idle("rst_mid");
      check("rst_mid_addr", 32'(mem_addr), 32'h0);
      check("rst_mid_data", 32'(rsp_data), 32'h0);
      check("rst_mid_err",  32'(rsp_err),  32'h0);
      cyc();
      check("rst_mid_novalid", 32'(rsp_valid), 32'd0);
      req_valid = 1'b1; req_addr = 10'h001;
      cyc();
      req_valid = 1'b0;
      check("rst_after_rd_en", 32'(mem_rd_en), 32'd1);
      check("rst_after_addr",  32'(mem_addr),  32'h001);
      mem_ack = 1'b1; mem_rdata = 18'h00777;
      cyc();
      mem_ack = 1'b0;
      check("rst_after_valid", 32'(rsp_valid), 32'd1);
      check("rst_after_data",  32'(rsp_data),  32'h00777);
      cyc();
      check_idle("rst_after_done");

      // Back-to-back zero-wait reads
      req_valid = 1'b1; req_addr = b2b_addr[0];
      for (int k = 0; k < 4; k++) begin
         cyc();
         check("b2b_rd_en", 32'(mem_rd_en), 32'd1);
         check("b2b_addr",  32'(mem_addr),  32'(b2b_addr[k]));
         mem_ack = 1'b1; mem_rdata = b2b_data[k];
         cyc();
         mem_ack = 1'b0;
         check("b2b_valid", 32'(rsp_valid), 32'd1);
         check("b2b_data",  32'(rsp_data),  32'(b2b_data[k]));
         if (k > 0) check("b2b_spacing", 32'(cycle_cnt - last_rsp), 32'd3);
         last_rsp = cycle_cnt;
         if (k < 3) req_addr = b2b_addr[k+1];
         else req_valid = 1'b0;
         cyc();
         check("b2b_idle", 32'(req_ready), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
